depth_event_axis_tx: RTL

- Transmit end of the depth-event path: accepts normalized `depth_event_t` records (from `binance_depth_types`) on a valid/ready input.
- Serializes each record into a fixed 8-beat, 32-bit AXI4-Stream frame for the PL→PS DMA path.
- Each frame carries a sync byte and a 16-bit frame sequence number, so PS software can detect loss and resynchronise.
- Sits between the Stage 4 depth parser and the AXI DMA S2MM port.

---
 rtl/depth_event_axis_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/depth_event_axis_tx.sv
// Serialises depth_event_t records into fixed 8-beat, 32-bit AXI4-Stream frames
// carrying a sync byte and a 16-bit frame sequence number for the PL->PS DMA path.
module depth_event_axis_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [218:0] in_event,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tlast,
    output logic [15:0]  frame_seq,
    output logic [31:0]  frames_sent
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [2:0]     beat_idx;
    logic [2:0]     beat_next;
    logic [218:0]   ev_q;
    logic [15:0]    seq_q;
    logic [15:0]    seq_cnt;
    logic [31:0]    sent_cnt;
    logic           load;
    logic           ready_raw;
    logic           last_fire;

    // depth_event_t packing, MSB first:
    // rec_type(2) side(1) symbol_id(16) ts_rx_ns(64) update_id(64) price_fp(32) qty_fp(32) flags(8)
    logic [1:0]     rec_type;
    logic           side;
    logic [15:0]    symbol_id;
    logic [63:0]    ts_rx_ns;
    logic [63:0]    update_id;
    logic [31:0]    price_fp;
    logic [31:0]    qty_fp;
    logic [7:0]     flags;

    assign rec_type  = ev_q[218:217];
    assign side      = ev_q[216];
    assign symbol_id = ev_q[215:200];
    assign ts_rx_ns  = ev_q[199:136];
    assign update_id = ev_q[135:72];
    assign price_fp  = ev_q[71:40];
    assign qty_fp    = ev_q[39:8];
    assign flags     = ev_q[7:0];

    always_comb begin
        state_next    = state;
        beat_next     = beat_idx;
        load          = 1'b0;
        ready_raw     = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state)
            IDLE: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SEND;
                    beat_next  = '0;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                // Last-beat handshake frees the holding register in the same cycle.
                ready_raw     = (beat_idx == 3'd7) && m_axis_tready;
                if (m_axis_tready) begin
                    beat_next = beat_idx + 3'd1;
                    if (beat_idx == 3'd7) begin
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = rst_n & ready_raw;
    assign last_fire = m_axis_tvalid && m_axis_tready && (beat_idx == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_idx <= '0;
            ev_q     <= '0;
            seq_q    <= '0;
            seq_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            state    <= state_next;
            beat_idx <= beat_next;
            if (load) begin
                ev_q  <= in_event;
                seq_q <= last_fire ? (seq_cnt + 16'd1) : seq_cnt;
            end
            if (last_fire) begin
                seq_cnt  <= seq_cnt + 16'd1;
                sent_cnt <= sent_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            case (beat_idx)
                3'd0: m_axis_tdata = {SYNC_BYTE, rec_type, side, 5'b00000, symbol_id};
                3'd1: m_axis_tdata = ts_rx_ns[63:32];
                3'd2: m_axis_tdata = ts_rx_ns[31:0];
                3'd3: m_axis_tdata = update_id[63:32];
                3'd4: m_axis_tdata = update_id[31:0];
                3'd5: m_axis_tdata = price_fp;
                3'd6: m_axis_tdata = qty_fp;
                default: begin
                    m_axis_tdata = {flags, 8'h00, seq_q};
                    m_axis_tlast = 1'b1;
                end
            endcase
        end
    end

    assign frame_seq   = seq_cnt;
    assign frames_sent = sent_cnt;

endmodule
